// File: rtl/pifo_calendar_array_v0_3_pkg.sv
// Shared definitions for the PIFO calendar array: default geometry, cell
// operation codes, and the rank extract / compare helpers.
package pifo_pkg;

  localparam int ELEMENT_WIDTH_DEF       = 32;
  localparam int RANK_WIDTH_DEF          = 19;
  localparam int RANK_START_POS_DEF      = 12;
  localparam int PIFO_INFO_VALID_POS_DEF = 31;
  localparam int EXT_W                   = 64;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INS    = 3'd1,
    OP_POP    = 3'd2,
    OP_INSPOP = 3'd3,
    OP_CPU    = 3'd4
  } cell_op_e;

  function automatic logic [EXT_W-1:0] rank_extract(input logic [EXT_W-1:0] elem,
                                                    input int unsigned start,
                                                    input int unsigned width);
    logic [EXT_W-1:0] mask;
    mask = (width >= EXT_W) ? {EXT_W{1'b1}} : ((64'd1 << width) - 64'd1);
    return (elem >> start) & mask;
  endfunction

  function automatic logic rank_greater(input logic [EXT_W-1:0] a,
                                        input logic [EXT_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/pifo_calendar_array_v0_3_cell.sv
// One PIFO slot: holds an element, reports whether it sits at/after the
// insert position, and selects its next value from its neighbours.
module pifo_calendar_cell
  import pifo_pkg::*;
#(
  parameter int ELEMENT_WIDTH       = ELEMENT_WIDTH_DEF,
  parameter int RANK_WIDTH          = RANK_WIDTH_DEF,
  parameter int RANK_START_POS      = RANK_START_POS_DEF,
  parameter int PIFO_INFO_VALID_POS = PIFO_INFO_VALID_POS_DEF,
  parameter bit IS_HEAD             = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cell_op_e                 op_i,
  input  logic [ELEMENT_WIDTH-1:0] ins_data_i,
  input  logic [ELEMENT_WIDTH-1:0] cpu_data_i,
  input  logic [ELEMENT_WIDTH-1:0] prev_data_i,
  input  logic [ELEMENT_WIDTH-1:0] next_data_i,
  input  logic                     prev_after_i,
  input  logic                     next_after_i,
  output logic                     after_o,
  output logic [ELEMENT_WIDTH-1:0] data_o
);

  logic [ELEMENT_WIDTH-1:0] data_q, data_d;

  // Empty slots and strictly larger ranks lie at or beyond the insert point,
  // so equal ranks stay ahead of the newcomer.
  always_comb begin
    after_o = ~data_q[PIFO_INFO_VALID_POS] |
              rank_greater(rank_extract(EXT_W'(data_q), RANK_START_POS, RANK_WIDTH),
                           rank_extract(EXT_W'(ins_data_i), RANK_START_POS, RANK_WIDTH));
  end

  always_comb begin
    data_d = data_q;
    case (op_i)
      OP_INS:    data_d = after_o ? (prev_after_i ? prev_data_i : ins_data_i) : data_q;
      OP_POP:    data_d = next_data_i;
      // Position is judged against the survivors: slot i+1 moves in unless
      // it is already past the insert point.
      OP_INSPOP: begin
        if (!next_after_i) begin
          data_d = next_data_i;
        end else if (IS_HEAD || !after_o) begin
          data_d = ins_data_i;
        end else begin
          data_d = data_q;
        end
      end
      OP_CPU:    data_d = cpu_data_i;
      default:   data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pifo_calendar_array_v0_3.sv
// Register-based PIFO ordered by rank, single-cycle insert/pop.
// Optional CPU slot-write port enabled by defining PIFO_CPU_WRITE_EN.
module pifo_calendar_array_v0_3
  import pifo_pkg::*;
#(
  parameter int ELEMENT_WIDTH       = ELEMENT_WIDTH_DEF,
  parameter int RANK_WIDTH          = RANK_WIDTH_DEF,
  parameter int RANK_START_POS      = RANK_START_POS_DEF,
  parameter int PIFO_INFO_VALID_POS = PIFO_INFO_VALID_POS_DEF,
  parameter int DEPTH               = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_insert_valid,
  input  logic [ELEMENT_WIDTH-1:0] in_insert_data,
  output logic                     out_insert_ready,
  input  logic                     in_pop,
  output logic                     out_pop_valid,
  output logic [ELEMENT_WIDTH-1:0] out_pop_data,
  output logic [CW-1:0]            out_count,
  output logic                     out_full,
  output logic                     out_empty,
`ifdef PIFO_CPU_WRITE_EN
  input  logic                     in_cpu_wr,
  input  logic [AW-1:0]            in_cpu_addr,
  input  logic [ELEMENT_WIDTH-1:0] in_cpu_data,
  output logic                     out_cpu_ack,
`endif
  output logic                     out_pop_err
);

  logic [ELEMENT_WIDTH-1:0] slot_s  [DEPTH];
  logic                     after_s [DEPTH];
  cell_op_e                 cell_op_s [DEPTH];
  cell_op_e                 op_s;
  logic                     ins_acc_s, ins_eff_s, pop_acc_s;
  logic                     pop_err_q;
  logic [CW-1:0]            count_s;

  always_comb begin
    count_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_s = count_s + CW'(slot_s[i][PIFO_INFO_VALID_POS]);
    end
  end

  assign out_count        = count_s;
  assign out_empty        = (count_s == '0);
  assign out_full         = (count_s == CW'(DEPTH));
  assign out_pop_valid    = slot_s[0][PIFO_INFO_VALID_POS];
  assign out_pop_data     = slot_s[0];
  assign out_insert_ready = ~out_full | (in_pop & out_pop_valid);
  assign out_pop_err      = pop_err_q;

  // A valid-bit-0 element is still accepted (ins_acc_s) but leaves no trace.
  assign ins_acc_s = in_insert_valid & out_insert_ready;
  assign ins_eff_s = ins_acc_s & in_insert_data[PIFO_INFO_VALID_POS];
  assign pop_acc_s = in_pop & out_pop_valid;

  always_comb begin
    op_s = OP_HOLD;
    case ({ins_eff_s, pop_acc_s})
      2'b10:   op_s = OP_INS;
      2'b01:   op_s = OP_POP;
      2'b11:   op_s = OP_INSPOP;
      default: op_s = OP_HOLD;
    endcase
  end

`ifdef PIFO_CPU_WRITE_EN
  logic cpu_ack_q, cpu_go_s, cpu_wr_s;

  // The ack cycle itself is blocked so a still-held request does not re-fire.
  assign cpu_go_s    = in_cpu_wr & ~cpu_ack_q & ~ins_acc_s & ~pop_acc_s;
  assign cpu_wr_s    = cpu_go_s & (32'(in_cpu_addr) < DEPTH);
  assign out_cpu_ack = cpu_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack_q <= 1'b0;
    end else begin
      cpu_ack_q <= cpu_go_s;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cpu_wr_s && (in_cpu_addr == AW'(i))) begin
        cell_op_s[i] = OP_CPU;
      end else begin
        cell_op_s[i] = op_s;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_op_s[i] = op_s;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_err_q <= 1'b0;
    end else begin
      pop_err_q <= in_pop & ~out_pop_valid;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic                     prev_after_s, next_after_s;
    logic [ELEMENT_WIDTH-1:0] prev_data_s, next_data_s, cpu_data_s;

    if (g == 0) begin : g_head
      assign prev_after_s = 1'b0;
      assign prev_data_s  = '0;
    end else begin : g_body
      assign prev_after_s = after_s[g-1];
      assign prev_data_s  = slot_s[g-1];
    end

    if (g == DEPTH - 1) begin : g_tail
      assign next_after_s = 1'b1;
      assign next_data_s  = '0;
    end else begin : g_inner
      assign next_after_s = after_s[g+1];
      assign next_data_s  = slot_s[g+1];
    end

`ifdef PIFO_CPU_WRITE_EN
    assign cpu_data_s = in_cpu_data;
`else
    assign cpu_data_s = '0;
`endif

    pifo_calendar_cell #(
      .ELEMENT_WIDTH      (ELEMENT_WIDTH),
      .RANK_WIDTH         (RANK_WIDTH),
      .RANK_START_POS     (RANK_START_POS),
      .PIFO_INFO_VALID_POS(PIFO_INFO_VALID_POS),
      .IS_HEAD            (g == 0)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .op_i        (cell_op_s[g]),
      .ins_data_i  (in_insert_data),
      .cpu_data_i  (cpu_data_s),
      .prev_data_i (prev_data_s),
      .next_data_i (next_data_s),
      .prev_after_i(prev_after_s),
      .next_after_i(next_after_s),
      .after_o     (after_s[g]),
      .data_o      (slot_s[g])
    );
  end

endmodule

// File: doc/pifo_calendar_array_v0_3.md
PIFO_CALENDAR_ARRAY_V0_3 -- requirements
Module: pifo_calendar_array_v0_3

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter RANK_WIDTH, default 19, rank field width.
REQ-003 SHALL have parameter RANK_START_POS, default 12, rank LSB; rank MSB = RANK_START_POS+RANK_WIDTH-1.
REQ-004 SHALL have parameter PIFO_INFO_VALID_POS, default 31, element valid bit.
REQ-005 SHALL have parameter DEPTH, default 16 (2..256), number of slots; CW = clog2(DEPTH+1), AW = clog2(DEPTH).
REQ-006 SHALL have ports clk, input, 1, sole clock; rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have ports in_insert_valid, input, 1; in_insert_data, input, ELEMENT_WIDTH; out_insert_ready, output, 1.
REQ-008 SHALL have ports in_pop, input, 1, pop request; out_pop_valid, output, 1, head valid; out_pop_data, output, ELEMENT_WIDTH, head element.
REQ-009 SHALL have ports out_count, output, CW, occupancy; out_full, output, 1; out_empty, output, 1; out_pop_err, output, 1, pop-on-empty pulse.
REQ-010 SHALL have ports in_cpu_wr, input, 1; in_cpu_addr, input, AW; in_cpu_data, input, ELEMENT_WIDTH; out_cpu_ack, output, 1 (present only under PIFO_CPU_WRITE_EN).

Function
REQ-011 SHALL hold DEPTH registered slots, slot 0 = head; valid slots contiguous from slot 0, ascending rank (unsigned), equal ranks in arrival order (new element after all equal ranks).
REQ-012 SHALL drive out_pop_data = slot 0 and out_pop_valid = slot 0 valid bit, directly from registers.
REQ-013 SHALL drive out_count = popcount of slot valid bits, out_empty = (count==0), out_full = (count==DEPTH), all register-derived.
REQ-014 SHALL drive out_insert_ready = ~out_full | (in_pop & out_pop_valid).
REQ-015 SHALL accept insert when in_insert_valid & out_insert_ready & in_insert_data[PIFO_INFO_VALID_POS]; element with valid bit 0 SHALL be accepted but discarded with no state change.
REQ-016 SHALL accept pop when in_pop & out_pop_valid; pop on empty SHALL change no slot and pulse out_pop_err for one cycle, registered.
REQ-017 SHALL complete any accepted insert and/or pop in one cycle; result visible on outputs the cycle after acceptance.
REQ-018 Insert only: slot at insert position takes new element, slots at and beyond it shift one toward tail.
REQ-019 Pop only: every slot i takes slot i+1; slot DEPTH-1 becomes 0.
REQ-020 Simultaneous insert and pop: position computed against remaining elements after head removal; slots before position shift toward head, slot at position takes new element, count unchanged; legal when full.
REQ-021 Insert into empty array (with or without pop) SHALL place element in slot 0.

Reset
REQ-022 SHALL, while rst is high, clear all slots to 0, out_pop_err to 0, out_cpu_ack to 0, regardless of clk; outputs: out_empty=1, out_full=0, out_count=0, out_insert_ready=1, out_pop_valid=0.
REQ-023 SHALL drop any in-flight insert, pop or CPU write when rst asserts; no partial update.

Configuration
REQ-024 With PIFO_CPU_WRITE_EN defined: CPU write to slot in_cpu_addr SHALL apply only in a cycle with no accepted insert or pop (valid-bit-0 inserts count as accepted); in_cpu_wr held until out_cpu_ack, one-cycle pulse the cycle after the write; addr >= DEPTH SHALL be acked with no write; ordering/contiguity after CPU writes is software's responsibility.
REQ-025 Without PIFO_CPU_WRITE_EN: CPU ports and logic absent; array changes only by insert/pop.

Structure
REQ-026 Shared package pifo_pkg SHALL hold default widths, valid/rank positions, and the rank-extract and rank-compare functions.
REQ-027 SHALL instantiate DEPTH copies of sub-module pifo_calendar_cell (one slot: register, compare-larger output, next-value mux from head/tail neighbours, input, CPU data).

Verification
REQ-028 Reset then insert ranks 5,3,9 on consecutive cycles -> slots 3,5,9; out_count=3, out_pop_data rank 3.
REQ-029 Insert two rank-7 elements tagged A then B, pop twice -> A then B (FIFO tie).
REQ-030 DEPTH=4 fill ranks 1,2,3,4 -> out_full=1, out_insert_ready=0; with in_pop high, insert rank 0 -> slots 0,2,3,4, count 4.
REQ-031 Empty array, in_pop pulse -> out_pop_err=1 next cycle only, count 0; simultaneous insert rank 8 + pop on empty -> slot 0 rank 8, count 1.
REQ-032 PIFO_CPU_WRITE_EN: in_cpu_wr addr 2 during continuous inserts -> no ack until idle cycle, ack pulse next cycle, slot 2 = in_cpu_data; rst mid-sequence -> all slots 0 next observation.
